topk_readout: RTL and testbench
===============================

Name: topk_readout

Overview:
- Streaming top-K tracker with a readout port.
- Write side: accepts an unsigned sample stream and keeps the K largest values seen since the last drain, sorted in descending order.
- Read side: on a drain request, emits the held values largest-first over a valid/ready interface, then clears itself for the next window.
- Sits downstream of the running max / second-largest monitors; it is the consumer that reports the ranked values out.

Parameters:
- DATA_WIDTH, 32, bit width of samples and of dout.
- K, 4, number of ranked slots held (K >= 2).
- CNT_W, $clog2(K+1), width of the count output (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- din_valid  input  1  sample strobe, one sample per cycle.
- din  input  DATA_WIDTH  unsigned sample.
- drain  input  1  single-cycle request to start readout.
- dout_valid  output  1  readout beat valid.
- dout_ready  input  1  downstream accepts beat.
- dout  output  DATA_WIDTH  ranked value, largest first.
- dout_last  output  1  marks the final beat of a drain.
- busy  output  1  high while in DRAIN.
- count  output  CNT_W  number of occupied slots, 0..K.
- din_drop  output  1  one-cycle pulse when a sample is discarded because the block is draining.

Behaviour:
- One clock domain; reset is asynchronous and active-high.
- Reset: all slots = 0, count = 0, state = COLLECT. dout_valid, dout_last, busy, din_drop = 0. dout = 0.
- States: COLLECT and DRAIN.
- COLLECT, din_valid=1: insert din into the sorted slot array on the same edge.
  - Comparison is unsigned.
  - Insert position is the first slot i with din > slot[i]. Ties go below existing equal entries (stable). Slots at i and below shift down by one.
  - If count < K, count increments and the value is always placed.
  - If count == K and din <= slot[K-1], the sample is discarded silently. This is not a drop event.
- COLLECT, drain=1:
  - If count > 0, go to DRAIN next cycle.
  - If count == 0, drain is ignored and no beat is emitted.
  - If din_valid and drain coincide, the sample is inserted first and the drain includes it.
- DRAIN:
  - busy = 1, dout_valid = 1, dout = slot[idx], where idx starts at 0.
  - dout_last = (idx == count-1).
  - On dout_valid & dout_ready: idx increments. On the last beat, all slots are cleared to 0, count = 0, idx = 0, and state returns to COLLECT on the following cycle.
  - dout and dout_last must hold stable while dout_valid=1 and dout_ready=0.
  - din_valid in DRAIN: the sample is discarded and din_drop pulses in that same cycle (registered: visible the cycle after the sample, for one cycle per dropped sample).
  - drain in DRAIN is ignored.
- Latency: first beat appears 1 cycle after drain is sampled. With dout_ready held high, a drain of n entries takes n cycles. The first sample accepted after the last beat is the cycle after the last handshake.
- Outside DRAIN: dout = 0 and dout_last = 0.
- count is visible on the cycle after each insertion.
- Reset mid-drain: the drain is abandoned immediately. Outputs take their reset values asynchronously and no partial beat remains.

Decomposition:
- Shared package topk_pkg holds:
  - state enum topk_state_e {ST_COLLECT, ST_DRAIN}.
  - Default constants TOPK_DEFAULT_K = 4 and TOPK_DEFAULT_DW = 32.
- One sub-module is natural: topk_slot_cell, one ranked register with its comparator and shift-in mux, instantiated K times in a generate chain.
- Top level holds the state machine, idx/count counters and the readout mux.

Test Plan:
- Reset, then stream din = 5, 9, 1, 9, 3, 7 and pulse drain; dout_ready=1 -> beats 9, 9, 7, 5 with dout_last on the 4th beat. count reads 4 before the drain and 0 after.
- Stream 10, 20, then drain with dout_ready toggling 1,0,0,1 -> beats 20, then 10, held stable through the stall cycles. dout_last only on 10. Exactly 2 beats.
- drain with count=0 -> no dout_valid, busy stays 0. Then din=0x10 with drain in the same cycle -> single beat 0x10 with dout_last.
- Insert 3, then drain. Assert din_valid with din=100 on the cycle dout_valid first rises -> din_drop pulses once, beat is 3 only. A following drain with count=0 emits nothing.
- K=4, feed 0xFFFFFFFF, 0, 0xFFFFFFFF, 0x80000000, 1 -> drain yields 0xFFFFFFFF, 0xFFFFFFFF, 0x80000000, 1. This checks unsigned ordering and the boundary values.
- Start a drain of 4 entries, assert reset after the 2nd handshake -> dout_valid drops asynchronously, count = 0. A subsequent drain emits nothing.

Source files
------------

// File: rtl/topk_pkg.sv
// rtl/topk_pkg.sv - shared state type and default sizes for the top-K readout block
package topk_pkg;

    typedef enum logic {
        ST_COLLECT,
        ST_DRAIN
    } topk_state_e;

    localparam int TOPK_DEFAULT_K  = 4;
    localparam int TOPK_DEFAULT_DW = 32;

endpackage

// File: rtl/topk_slot_cell.sv
// rtl/topk_slot_cell.sv - one ranked slot: comparator plus insert/shift-in mux
module topk_slot_cell
    import topk_pkg::*;
#(
    parameter int DW = TOPK_DEFAULT_DW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ins,
    input  logic          clr,
    input  logic          occ,
    input  logic          prev_take,
    input  logic [DW-1:0] din,
    input  logic [DW-1:0] prev_val,
    output logic          take,
    output logic [DW-1:0] val
);

    // Empty slots always accept; occupied ones only on strictly greater so ties land below.
    assign take = !occ || (din > val);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            val <= '0;
        end else if (clr) begin
            val <= '0;
        end else if (ins && take) begin
            val <= prev_take ? prev_val : din;
        end
    end

endmodule

// File: rtl/topk_readout.sv
// rtl/topk_readout.sv - streaming top-K tracker with ranked valid/ready readout
module topk_readout
    import topk_pkg::*;
#(
    parameter int DATA_WIDTH = TOPK_DEFAULT_DW,
    parameter int K          = TOPK_DEFAULT_K,
    localparam int CNT_W     = $clog2(K + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  din_valid,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  drain,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_last,
    output logic                  busy,
    output logic [CNT_W-1:0]      count,
    output logic                  din_drop
);

    topk_state_e state, state_nxt;

    logic [CNT_W-1:0]      idx;
    logic [DATA_WIDTH-1:0] slot_val [K];
    logic [DATA_WIDTH-1:0] prev_val [K];
    logic [K-1:0]          take;
    logic [K-1:0]          prev_take;
    logic [K-1:0]          occ;
    logic                  ins;
    logic                  beat;
    logic                  at_last;
    logic                  last_beat;

    assign ins       = (state == ST_COLLECT) && din_valid;
    assign beat      = (state == ST_DRAIN) && dout_ready;
    assign at_last   = (idx == count - CNT_W'(1));
    assign last_beat = beat && at_last;
    assign prev_take = {take[K-2:0], 1'b0};

    // Occupied slots always form a prefix, so the take flags are monotonic down the chain.
    for (genvar i = 0; i < K; i++) begin : g_cell
        assign occ[i] = (CNT_W'(i) < count);
        if (i == 0) begin : g_head
            assign prev_val[i] = '0;
        end else begin : g_body
            assign prev_val[i] = slot_val[i-1];
        end
        topk_slot_cell #(.DW(DATA_WIDTH)) u_cell (
            .clk       (clk),
            .reset     (reset),
            .ins       (ins),
            .clr       (last_beat),
            .occ       (occ[i]),
            .prev_take (prev_take[i]),
            .din       (din),
            .prev_val  (prev_val[i]),
            .take      (take[i]),
            .val       (slot_val[i])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_COLLECT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_COLLECT: if (drain && (count != '0 || din_valid)) state_nxt = ST_DRAIN;
            ST_DRAIN:   if (last_beat) state_nxt = ST_COLLECT;
            default:    state_nxt = ST_COLLECT;
        endcase
    end

    always_comb begin
        dout_valid = (state == ST_DRAIN);
        busy       = (state == ST_DRAIN);
        dout_last  = (state == ST_DRAIN) && at_last;
        dout       = '0;
        if (state == ST_DRAIN) begin
            for (int i = 0; i < K; i++) begin
                if (idx == CNT_W'(i)) dout = slot_val[i];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count    <= '0;
            idx      <= '0;
            din_drop <= 1'b0;
        end else begin
            din_drop <= (state == ST_DRAIN) && din_valid;
            if (last_beat) begin
                count <= '0;
                idx   <= '0;
            end else if (beat) begin
                idx <= idx + CNT_W'(1);
            end else if (ins && count < CNT_W'(K)) begin
                count <= count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_topk_readout.sv
// tb/tb_topk_readout.sv - randomized self-checking bench for topk_readout
module tb_topk_readout;

    localparam int K  = 4;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          din_valid;
    logic [DW-1:0] din;
    logic          drain;
    logic          dout_valid;
    logic          dout_ready;
    logic [DW-1:0] dout;
    logic          dout_last;
    logic          busy;
    logic [2:0]    count;
    logic          din_drop;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] model_q[$];
    logic [DW-1:0] got_q[$];
    logic          got_last[$];
    int            stall_err;
    int            timed_out;

    topk_readout #(.DATA_WIDTH(DW), .K(K)) dut (
        .clk        (clk),
        .reset      (reset),
        .din_valid  (din_valid),
        .din        (din),
        .drain      (drain),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout       (dout),
        .dout_last  (dout_last),
        .busy       (busy),
        .count      (count),
        .din_drop   (din_drop)
    );

    always #5 clk = ~clk;

    // Reference: keep everything seen, sort descending, keep the K largest.
    task automatic model_insert(input logic [DW-1:0] v);
        model_q.push_back(v);
        model_q.rsort();
        if (model_q.size() > K) model_q.pop_back();
    endtask

    task automatic feed(input logic [DW-1:0] v);
        @(negedge clk);
        din_valid = 1'b1;
        din       = v;
        model_insert(v);
    endtask

    task automatic idle;
        @(negedge clk);
        din_valid = 1'b0;
        drain     = 1'b0;
    endtask

    // mode 0: ready always high, 1: random ready, 2: ready pattern 1,0,0,1
    task automatic run_drain(input int mode, input int limit);
        int cyc;
        int have_prev;
        logic [DW-1:0] prev_d;
        logic prev_l;
        logic r;
        int pat[4] = '{1, 0, 0, 1};
        got_q.delete();
        got_last.delete();
        stall_err = 0;
        timed_out = 0;
        have_prev = 0;
        prev_d    = '0;
        prev_l    = 1'b0;
        @(negedge clk);
        drain = 1'b1;
        @(negedge clk);
        drain = 1'b0;
        cyc = 0;
        while (dout_valid && cyc < limit) begin
            if (have_prev != 0 && (dout !== prev_d || dout_last !== prev_l)) stall_err++;
            r = (mode == 0) ? 1'b1 : (mode == 1) ? 1'($urandom_range(0, 1)) : 1'(pat[cyc % 4]);
            dout_ready = r;
            if (r) begin
                got_q.push_back(dout);
                got_last.push_back(dout_last);
                have_prev = 0;
            end else begin
                have_prev = 1;
                prev_d    = dout;
                prev_l    = dout_last;
            end
            cyc++;
            @(negedge clk);
        end
        dout_ready = 1'b0;
        if (cyc >= limit) timed_out = 1;
    endtask

    task automatic check_drain_vs_model(input string name);
        checks++;
        if (timed_out != 0 || stall_err != 0) begin
            failures++;
            $display("FAIL %s handshake: timed_out=%0d stall_err=%0d expected 0/0", name, timed_out, stall_err);
        end
        checks++;
        if (got_q.size() != model_q.size()) begin
            failures++;
            $display("FAIL %s beat_count: got %0d expected %0d", name, got_q.size(), model_q.size());
        end else begin
            for (int i = 0; i < got_q.size(); i++) begin
                checks++;
                if (got_q[i] !== model_q[i] || got_last[i] !== (i == got_q.size() - 1)) begin
                    failures++;
                    $display("FAIL %s beat%0d: got %h last=%b expected %h last=%b", name, i,
                             got_q[i], got_last[i], model_q[i], (i == got_q.size() - 1));
                end
            end
        end
        model_q.delete();
    endtask

    task automatic test_reset;
        reset = 1'b1;
        din_valid = 1'b0; din = '0; drain = 1'b0; dout_ready = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({dout_valid, dout_last, busy, din_drop} !== 4'b0 || count !== 3'd0 || dout !== '0) begin
            failures++;
            $display("FAIL reset_state: valid=%b last=%b busy=%b drop=%b count=%0d dout=%h expected all zero",
                     dout_valid, dout_last, busy, din_drop, count, dout);
        end
        reset = 1'b0;
        model_q.delete();
    endtask

    task automatic test_basic;
        logic [DW-1:0] vals[6] = '{5, 9, 1, 9, 3, 7};
        foreach (vals[i]) feed(vals[i]);
        idle();
        checks++;
        if (count !== 3'd4) begin
            failures++;
            $display("FAIL basic_count: got %0d expected 4", count);
        end
        run_drain(0, 64);
        check_drain_vs_model("basic");
        checks++;
        if (count !== 3'd0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL basic_after: count=%0d busy=%b expected 0/0", count, busy);
        end
    endtask

    task automatic test_stall;
        feed(10);
        feed(20);
        idle();
        run_drain(2, 64);
        checks++;
        if (got_q.size() != 2 || got_q[0] !== 32'd20 || got_q[1] !== 32'd10) begin
            failures++;
            $display("FAIL stall_seq: got %0d beats expected 20,10", got_q.size());
        end
        check_drain_vs_model("stall");
    endtask

    task automatic test_empty_and_coincident;
        @(negedge clk);
        drain = 1'b1;
        @(negedge clk);
        drain = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (dout_valid !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL empty_drain: valid=%b busy=%b expected 0/0", dout_valid, busy);
            end
            @(negedge clk);
        end
        din_valid = 1'b1; din = 32'h10; drain = 1'b1;
        @(negedge clk);
        din_valid = 1'b0; drain = 1'b0;
        checks++;
        if (dout_valid !== 1'b1 || dout !== 32'h10 || dout_last !== 1'b1) begin
            failures++;
            $display("FAIL coincident_beat: valid=%b dout=%h last=%b expected 1/10/1", dout_valid, dout, dout_last);
        end
        dout_ready = 1'b1;
        @(negedge clk);
        dout_ready = 1'b0;
        checks++;
        if (dout_valid !== 1'b0 || count !== 3'd0) begin
            failures++;
            $display("FAIL coincident_end: valid=%b count=%0d expected 0/0", dout_valid, count);
        end
    endtask

    task automatic test_drop;
        feed(3);
        idle();
        drain = 1'b1;
        @(negedge clk);
        drain = 1'b0;
        checks++;
        if (dout_valid !== 1'b1 || dout !== 32'd3 || dout_last !== 1'b1) begin
            failures++;
            $display("FAIL drop_beat: valid=%b dout=%h last=%b expected 1/3/1", dout_valid, dout, dout_last);
        end
        din_valid = 1'b1; din = 100; dout_ready = 1'b1;
        @(negedge clk);
        din_valid = 1'b0; dout_ready = 1'b0;
        checks++;
        if (din_drop !== 1'b1 || dout_valid !== 1'b0 || count !== 3'd0) begin
            failures++;
            $display("FAIL drop_pulse: drop=%b valid=%b count=%0d expected 1/0/0", din_drop, dout_valid, count);
        end
        @(negedge clk);
        checks++;
        if (din_drop !== 1'b0) begin
            failures++;
            $display("FAIL drop_single: drop=%b expected 0", din_drop);
        end
        model_q.delete();
        run_drain(0, 16);
        checks++;
        if (got_q.size() != 0) begin
            failures++;
            $display("FAIL drop_after_empty: got %0d beats expected 0", got_q.size());
        end
    endtask

    task automatic test_unsigned;
        logic [DW-1:0] vals[5] = '{32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFF, 32'h8000_0000, 32'h1};
        foreach (vals[i]) feed(vals[i]);
        idle();
        run_drain(1, 64);
        check_drain_vs_model("unsigned");
    endtask

    task automatic test_reset_mid_drain;
        for (int i = 0; i < 4; i++) feed(32'($urandom_range(1, 1000)));
        idle();
        drain = 1'b1;
        @(negedge clk);
        drain = 1'b0;
        dout_ready = 1'b1;
        repeat (2) @(negedge clk);
        dout_ready = 1'b0;
        #2 reset = 1'b1;
        #1;
        checks++;
        if (dout_valid !== 1'b0 || busy !== 1'b0 || count !== 3'd0 || dout !== '0) begin
            failures++;
            $display("FAIL reset_mid_drain: valid=%b busy=%b count=%0d dout=%h expected 0", dout_valid, busy, count, dout);
        end
        @(negedge clk);
        reset = 1'b0;
        model_q.delete();
        run_drain(0, 16);
        checks++;
        if (got_q.size() != 0) begin
            failures++;
            $display("FAIL reset_then_drain: got %0d beats expected 0", got_q.size());
        end
    endtask

    task automatic test_random;
        int n;
        for (int w = 0; w < 20; w++) begin
            n = $urandom_range(0, 9);
            for (int j = 0; j < n; j++) begin
                @(negedge clk);
                din_valid = ($urandom_range(0, 4) != 0);
                din = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 15)) : 32'($urandom);
                if (din_valid) model_insert(din);
            end
            idle();
            checks++;
            if (count !== 3'(model_q.size())) begin
                failures++;
                $display("FAIL random_count w%0d: got %0d expected %0d", w, count, model_q.size());
            end
            run_drain(1, 64);
            check_drain_vs_model("random");
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_empty_and_coincident();
        test_drop();
        test_unsigned();
        test_reset_mid_drain();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
